reg_bank_reader: RTL and testbench

- Read-side companion to the team's enable-gated 32-bit general register: a 16-entry bank of such registers plus a sequential readout engine.
- On a start command the engine streams a contiguous run of registers, with wrap-around, onto a valid/ready output port, one word per handshake.
- Used for register-file dump, debug readout and bus-transfer sequencing in the CPU datapath.

---
 rtl/reg_bank_reader.sv | 102 ++++++++++
 tb/tb_reg_bank_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// Bank of DEPTH enable-gated registers with a sequential readout engine that
// streams a contiguous, wrapping run of entries onto a valid/ready port.
module reg_bank_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [0:0]       r_state;
  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_remaining;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [AW-1:0]    r_out_idx;
  logic             r_done;

  logic [AW-1:0]    w_ptr_next;
  logic             w_handshake;
  logic             w_last;

  // AW-bit pointer arithmetic gives the DEPTH-1 -> 0 wrap for free.
  assign w_ptr_next  = r_ptr + AW'(1);
  assign w_handshake = r_out_valid && out_ready;
  assign w_last      = (r_remaining == (AW + 1)'(1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else if (wr_en) begin
      r_bank[wr_addr] <= wr_data;
    end
  end

  // Loads read r_bank before the same-edge write lands, so a collision
  // captures the pre-write value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          if (count != '0) begin
            r_out_data  <= r_bank[base];
            r_out_idx   <= base;
            r_out_valid <= 1'b1;
            r_ptr       <= base;
            r_remaining <= count;
            r_state     <= ST_STREAM;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else if (w_handshake) begin
        if (w_last) begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_ptr       <= w_ptr_next;
          r_remaining <= r_remaining - (AW + 1)'(1);
          r_out_data  <= r_bank[w_ptr_next];
          r_out_idx   <= w_ptr_next;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state == ST_STREAM);
  assign done      = r_done;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Randomised and directed bench for reg_bank_reader against a queue-based
// behavioural model of the readout engine.
module tb_reg_bank_reader;

  logic        clk;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [3:0]  base;
  logic [4:0]  count;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  reg_bank_reader dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .base      (base),
    .count     (count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is a queue of register indices; the head word is what must
  // be on the output, its data captured from the bank when it became head.
  bit [31:0] m_bank [16];
  int        m_q [$];
  bit        m_busy;
  bit        m_done;
  bit [31:0] m_data;
  int        m_idx;

  task automatic mdl_reset();
    foreach (m_bank[i]) m_bank[i] = '0;
    m_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_data = '0;
    m_idx  = 0;
  endtask

  task automatic mdl_present();
    m_idx  = m_q[0];
    m_data = m_bank[m_q[0]];
  endtask

  task automatic mdl_step();
    m_done = 1'b0;
    if (!m_busy) begin
      if (start) begin
        if (count == 0) begin
          m_done = 1'b1;
        end else begin
          for (int k = 0; k < int'(count); k++) m_q.push_back((int'(base) + k) % 16);
          m_busy = 1'b1;
          mdl_present();
        end
      end
    end else if (out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        mdl_present();
      end
    end
    if (wr_en) m_bank[wr_addr] = wr_data;
  endtask

  always @(posedge clk or negedge clr) begin
    if (!clr) mdl_reset();
    else mdl_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("done_valid_excl", {31'd0, done & out_valid}, 32'd0);
      if (m_busy) begin
        chk("out_data", out_data, m_data);
        chk("out_idx", {28'd0, out_idx}, m_idx[31:0]);
      end
    end
  end

  // Handshake log: {idx, data} of every accepted word.
  logic [35:0] hs_q [$];
  always @(posedge clk) begin
    if (clr && out_valid && out_ready) hs_q.push_back({out_idx, out_data});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] b, input logic [4:0] c);
    start = 1'b1; base = b; count = c;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_word(input string nm, input logic [3:0] idx, input logic [31:0] d);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_idx"}, {28'd0, out_idx}, {28'd0, idx});
  endtask

  initial begin
    clr = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    #1 clr = 1'b0;
    step();
    step();
    check_en = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    clr = 1'b1;
    step();

    // Full dump after reset: sixteen zeros in index order.
    out_ready = 1'b1;
    hs_q.delete();
    start_run(4'd0, 5'd16);
    wait_done(40);
    chk("rst_dump_n", hs_q.size(), 32'd16);
    foreach (hs_q[i]) chk("rst_dump_word", {28'd0, hs_q[i]}, {28'd0, 4'(i), 32'd0});

    // Basic stream.
    wr(4'd3, 32'd10); wr(4'd4, 32'd20); wr(4'd5, 32'd30);
    hs_q.delete();
    start_run(4'd3, 5'd3);
    chk_word("basic0", 4'd3, 32'd10);
    step(); chk_word("basic1", 4'd4, 32'd20);
    step(); chk_word("basic2", 4'd5, 32'd30);
    step();
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_valid", {31'd0, out_valid}, 32'd0);
    chk("basic_hs", hs_q.size(), 32'd3);
    step();
    chk("basic_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure while word 20 is presented.
    hs_q.delete();
    start_run(4'd3, 5'd3);
    step();
    out_ready = 1'b0;
    step(); chk_word("bp_hold0", 4'd4, 32'd20);
    step(); chk_word("bp_hold1", 4'd4, 32'd20);
    out_ready = 1'b1;
    step(); chk_word("bp_next", 4'd5, 32'd30);
    wait_done(10);
    step();
    chk("bp_hs", hs_q.size(), 32'd3);

    // Wrap-around.
    wr(4'd15, 32'd7); wr(4'd0, 32'd9);
    start_run(4'd15, 5'd2);
    chk_word("wrap0", 4'd15, 32'd7);
    step(); chk_word("wrap1", 4'd0, 32'd9);
    step();
    chk("wrap_done", {31'd0, done}, 32'd1);

    // Collision: write R4 on the edge that loads R4.
    start_run(4'd3, 5'd3);
    wr(4'd4, 32'd40);
    chk_word("coll_old", 4'd4, 32'd20);
    wait_done(10);
    start_run(4'd4, 5'd1);
    chk_word("coll_new", 4'd4, 32'd40);
    step();
    chk("coll_done", {31'd0, done}, 32'd1);

    // count == 0.
    start_run(4'd2, 5'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("zero_done_pulse", {31'd0, done}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored.
    out_ready = 1'b0;
    hs_q.delete();
    start_run(4'd3, 5'd3);
    start_run(4'd0, 5'd5);
    chk_word("busy_start", 4'd3, 32'd10);
    out_ready = 1'b1;
    wait_done(10);
    step();
    chk("busy_start_hs", hs_q.size(), 32'd3);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Asynchronous clear mid-stream.
    start_run(4'd0, 5'd16);
    step(); step();
    clr = 1'b0;
    #1;
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    step();
    clr = 1'b1;
    step();
    hs_q.delete();
    start_run(4'd5, 5'd16);
    wait_done(40);
    chk("clr_dump_n", hs_q.size(), 32'd16);
    foreach (hs_q[i]) chk("clr_dump_data", hs_q[i][31:0], 32'd0);

    // Random traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = 4'($urandom);
      wr_data   = $urandom;
      start     = ($urandom_range(0, 3) == 0);
      base      = 4'($urandom);
      count     = 5'($urandom_range(0, 16));
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 599) == 0) begin
        clr = 1'b0;
        step();
        clr = 1'b1;
      end
      step();
    end
    wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
